icache_assoc: RTL

ICACHE_ASSOC -- requirements
Module: icache_assoc

---
 rtl/icache_assoc.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with a single-burst AXI read refill.
// Optional feature: define ICACHE_UNCACHED_EN to make pc[31:29]=101 fetches bypass the arrays.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   pc, advance, flush       fetch address, pipeline accept, invalidate-all request
//   inst, ready, busy        fetched word, word valid for pc, controller not idle
//   araddr, arlen, arvalid   AXI read address channel (registered)
//   arready, rvalid, rlast,  AXI read handshakes and data
//   rdata
module icache_assoc #(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 128,
  parameter int unsigned LINE_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        advance,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        ready,
  output logic        busy,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic        arvalid,
  input  logic        arready,
  input  logic        rvalid,
  input  logic        rlast,
  input  logic [31:0] rdata
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned LA_W  = IDX_W + OFF_W;
  localparam int unsigned TAG_W = 30 - LA_W;

  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_AR, ST_R, ST_END} state_t;

  state_t state_q, state_d;

  // Storage arrays
  logic [WAYS-1:0]  valid_q [SETS];
  logic             lru_q   [SETS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [31:0]      data_q  [WAYS][SETS*LINE_WORDS];

  // Miss context captured while idle
  logic [IDX_W-1:0] fill_idx_q;
  logic [TAG_W-1:0] fill_tag_q;
  logic             fill_way_q;
  logic             unc_q;
  logic [31:0]      unc_data_q;
  logic [OFF_W-1:0] word_cnt_q;
  logic [IDX_W-1:0] init_idx_q;
  logic             flush_pend_q, flush_pend_d;

  logic        arvalid_d;
  logic [31:0] araddr_d;
  logic [3:0]  arlen_d;

  logic [31:0]      paddr_c;
  logic [OFF_W-1:0] off_c;
  logic [IDX_W-1:0] idx_c;
  logic [TAG_W-1:0] tag_c;
  logic             uncached_c;
  logic             hit_c, hit_way_c, victim_c, rd_way_c;
  logic [LA_W-1:0]  rd_addr_c;
  logic             fill_we_c, tag_we_c, unc_we_c, lru_we_c, lru_val_c;
  logic [IDX_W-1:0] lru_idx_c;
  logic             unused_c;

  // Address translation and field split
  assign paddr_c  = (pc[31:30] == 2'b10) ? {3'b000, pc[28:0]} : pc;
  assign off_c    = paddr_c[OFF_W+1:2];
  assign idx_c    = paddr_c[LA_W+1:OFF_W+2];
  assign tag_c    = paddr_c[31:LA_W+2];
  assign unused_c = ^paddr_c[1:0];

`ifdef ICACHE_UNCACHED_EN
  assign uncached_c = (pc[31:29] == 3'b101);
`else
  assign uncached_c = 1'b0;
`endif

  // Tag compare across ways; uncached fetches never hit
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_c][w] && (tag_q[w][idx_c] == tag_c)) begin
        hit_c     = 1'b1;
        hit_way_c = 1'(w);
      end
    end
    if (uncached_c) hit_c = 1'b0;
  end

  // Victim: first invalid way, else the LRU-named way
  always_comb begin
    if (WAYS == 1)                     victim_c = 1'b0;
    else if (!valid_q[idx_c][0])       victim_c = 1'b0;
    else if (!valid_q[idx_c][WAYS-1])  victim_c = 1'b1;
    else                               victim_c = lru_q[idx_c];
  end

  // Data read: hitting way while idle, freshly filled way in END
  assign rd_way_c  = (state_q == ST_END) ? fill_way_q : hit_way_c;
  assign rd_addr_c = (state_q == ST_END) ? {fill_idx_q, off_c} : {idx_c, off_c};
  assign inst      = (state_q == ST_END && unc_q) ? unc_data_q : data_q[rd_way_c][rd_addr_c];
  assign busy      = (state_q != ST_IDLE);

  // Next-state, handshake and array-write decode
  always_comb begin
    state_d      = state_q;
    ready        = 1'b0;
    arvalid_d    = 1'b0;
    araddr_d     = '0;
    arlen_d      = '0;
    fill_we_c    = 1'b0;
    tag_we_c     = 1'b0;
    unc_we_c     = 1'b0;
    lru_we_c     = 1'b0;
    lru_val_c    = 1'b0;
    lru_idx_c    = idx_c;
    flush_pend_d = flush_pend_q;
    if (flush && (state_q == ST_AR || state_q == ST_R || state_q == ST_END)) flush_pend_d = 1'b1;

    case (state_q)
      ST_INIT: begin
        if (init_idx_q == IDX_W'(SETS - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_INIT;
        end else if (hit_c) begin
          ready = 1'b1;
          if (advance) begin
            lru_we_c  = 1'b1;
            lru_val_c = ~hit_way_c;
          end
        end else begin
          state_d   = ST_AR;
          arvalid_d = 1'b1;
          if (uncached_c) begin
            araddr_d = {paddr_c[31:2], 2'b00};
            arlen_d  = 4'd0;
          end else begin
            araddr_d = {paddr_c[31:OFF_W+2], {(OFF_W+2){1'b0}}};
            arlen_d  = 4'(LINE_WORDS - 1);
          end
        end
      end
      ST_AR: begin
        if (arready) begin
          state_d = ST_R;
        end else begin
          arvalid_d = 1'b1;
          araddr_d  = araddr;
          arlen_d   = arlen;
        end
      end
      ST_R: begin
        if (rvalid) begin
          if (unc_q) unc_we_c = 1'b1;
          else       fill_we_c = 1'b1;
          if (rlast) begin
            state_d = ST_END;
            if (!unc_q) begin
              tag_we_c  = 1'b1;
              lru_we_c  = 1'b1;
              lru_idx_c = fill_idx_q;
              lru_val_c = ~fill_way_q;
            end
          end
        end
      end
      ST_END: begin
        ready = 1'b1;
        if (advance) begin
          if (flush_pend_q || flush) begin
            state_d      = ST_INIT;
            flush_pend_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      init_idx_q   <= '0;
      word_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      arvalid      <= 1'b0;
      araddr       <= '0;
      arlen        <= '0;
      fill_idx_q   <= '0;
      fill_tag_q   <= '0;
      fill_way_q   <= 1'b0;
      unc_q        <= 1'b0;
      unc_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      arvalid      <= arvalid_d;
      araddr       <= araddr_d;
      arlen        <= arlen_d;
      init_idx_q   <= (state_q == ST_INIT) ? init_idx_q + IDX_W'(1) : '0;
      if (state_q == ST_IDLE) begin
        fill_idx_q <= idx_c;
        fill_tag_q <= tag_c;
        fill_way_q <= victim_c;
        unc_q      <= uncached_c;
      end
      if (state_q == ST_R && rvalid) word_cnt_q <= rlast ? '0 : word_cnt_q + OFF_W'(1);
      if (unc_we_c) unc_data_q <= rdata;
    end
  end

  // Array updates: INIT sweep clears one set per cycle; refill writes data, tag, valid, LRU
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_INIT) begin
        valid_q[init_idx_q] <= '0;
        lru_q[init_idx_q]   <= 1'b0;
      end else begin
        if (tag_we_c) begin
          tag_q[fill_way_q][fill_idx_q]   <= fill_tag_q;
          valid_q[fill_idx_q][fill_way_q] <= 1'b1;
        end
        if (lru_we_c) lru_q[lru_idx_c] <= lru_val_c;
      end
      if (fill_we_c) data_q[fill_way_q][{fill_idx_q, word_cnt_q}] <= rdata;
    end
  end

endmodule
